// File: rtl/mips_control_sequencer_pkg.sv
// Shared definitions for the MIPS control sequencer: opcode and funct
// constants, the ALU operation code, the sequencer state encoding and the
// static-control bundle carried from decode through the last phase of an
// instruction.
package mips_control_sequencer_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;
   localparam logic [5:0] OP_HALT   = 6'h3F;
   localparam logic [5:0] FUNCT_ADD = 6'h20;

   localparam logic [3:0] ALU_ADD   = 4'b0101;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_READ  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_WB    = 3'd4,
      ST_HALT  = 3'd5
   } state_e;

   // Controls that stay constant for the whole life of one instruction.
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic [3:0] alu_ctrl;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '{reg_dst: 1'b0, alu_src: 1'b0,
                                   mem_to_reg: 1'b0, alu_ctrl: 4'b0000};

endpackage

// File: rtl/mips_control_sequencer_instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   i_opcode  [5:0]  instruction bits 31:26
//   i_funct   [5:0]  instruction bits 5:0 (only meaningful for R-type)
//   o_ctrl           static controls for a legal instruction, else all zero
//   o_is_mem         lw or sw (instruction needs a MEM phase)
//   o_is_load        lw (MEM phase followed by WB)
//   o_illegal        unknown opcode or R-type other than add
//   o_halt           explicit halt opcode
module mips_control_sequencer_instr_decoder
   import mips_control_sequencer_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output ctrl_t      o_ctrl,
   output logic       o_is_mem,
   output logic       o_is_load,
   output logic       o_illegal,
   output logic       o_halt
);

   // Opcode/funct to control mapping.
   always_comb begin
      o_ctrl    = CTRL_NONE;
      o_is_mem  = 1'b0;
      o_is_load = 1'b0;
      o_illegal = 1'b0;
      o_halt    = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            if (i_funct == FUNCT_ADD) begin
               o_ctrl = '{reg_dst: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0, alu_ctrl: ALU_ADD};
            end else begin
               o_illegal = 1'b1;
            end
         end
         OP_ADDI: o_ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, alu_ctrl: ALU_ADD};
         OP_LW: begin
            o_ctrl    = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b1, alu_ctrl: ALU_ADD};
            o_is_mem  = 1'b1;
            o_is_load = 1'b1;
         end
         OP_SW: begin
            o_ctrl   = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, alu_ctrl: ALU_ADD};
            o_is_mem = 1'b1;
         end
         OP_HALT: o_halt = 1'b1;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_control_sequencer.sv
// Multi-cycle fetch/decode/control sequencer for the MIPS datapath.
// Owns the PC and instruction register, fetches from a combinational
// instruction ROM and sequences FETCH -> READ -> EXEC -> {MEM, WB} -> FETCH.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_run              permits new fetches (sampled in FETCH only)
//   o_imem_addr        ROM word address (PC[IMEM_AW+1:2])
//   i_imem_data        ROM read data
//   o_instruction      instruction register
//   o_reg_dst/o_alu_src/o_mem_to_reg/o_alu_control  static controls
//   o_reg_write/o_mem_read/o_mem_write               one-cycle strobes
//   o_pc               program counter
//   o_halt             sticky halt / illegal-opcode flag
//   o_retired          completed-instruction count
module mips_control_sequencer
   import mips_control_sequencer_pkg::*;
#(
   parameter int          IMEM_AW  = 6,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_run,
   output logic [IMEM_AW-1:0] o_imem_addr,
   input  logic [31:0]        i_imem_data,
   output logic [31:0]        o_instruction,
   output logic               o_reg_dst,
   output logic               o_reg_write,
   output logic               o_alu_src,
   output logic               o_mem_write,
   output logic               o_mem_read,
   output logic               o_mem_to_reg,
   output logic [3:0]         o_alu_control,
   output logic [31:0]        o_pc,
   output logic               o_halt,
   output logic [31:0]        o_retired
);

   // PC only spans the ROM byte range; upper bits stay zero after a wrap.
   localparam logic [31:0] PC_MASK = (32'd1 << (IMEM_AW + 2)) - 32'd1;

   state_e      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   ctrl_t       r_ctrl;
   logic        r_is_mem;
   logic        r_is_load;
   logic        r_stop;
   logic        r_reg_write;
   logic        r_mem_write;
   logic        r_mem_read;
   logic        r_halt;
   logic [31:0] r_retired;

   ctrl_t       w_dec_ctrl;
   logic        w_dec_is_mem;
   logic        w_dec_is_load;
   logic        w_dec_illegal;
   logic        w_dec_halt;
   logic [31:0] w_pc_next;

   // Decode straight from ROM data so controls are already registered in READ.
   mips_control_sequencer_instr_decoder u_decoder (
      .i_opcode  (i_imem_data[31:26]),
      .i_funct   (i_imem_data[5:0]),
      .o_ctrl    (w_dec_ctrl),
      .o_is_mem  (w_dec_is_mem),
      .o_is_load (w_dec_is_load),
      .o_illegal (w_dec_illegal),
      .o_halt    (w_dec_halt)
   );

   assign w_pc_next = (r_pc + 32'd4) & PC_MASK;

   // Sequencer FSM with registered controls, strobes, PC, IR and retire count.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= 32'h0;
         r_ctrl      <= CTRL_NONE;
         r_is_mem    <= 1'b0;
         r_is_load   <= 1'b0;
         r_stop      <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_halt      <= 1'b0;
         r_retired   <= 32'h0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (i_run) begin
                  r_ir      <= i_imem_data;
                  r_pc      <= w_pc_next;
                  r_ctrl    <= (w_dec_illegal || w_dec_halt) ? CTRL_NONE : w_dec_ctrl;
                  r_is_mem  <= w_dec_is_mem;
                  r_is_load <= w_dec_is_load;
                  r_stop    <= w_dec_illegal || w_dec_halt;
                  r_state   <= ST_READ;
               end else begin
                  r_state   <= ST_FETCH;
               end
            end
            ST_READ: begin
               if (r_stop) begin
                  r_halt  <= 1'b1;
                  r_ctrl  <= CTRL_NONE;
                  r_state <= ST_HALT;
               end else begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (r_is_mem) begin
                  r_mem_read  <= r_is_load;
                  r_mem_write <= !r_is_load;
                  r_state     <= ST_MEM;
               end else begin
                  r_reg_write <= 1'b1;
                  r_state     <= ST_WB;
               end
            end
            ST_MEM: begin
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
               if (r_is_load) begin
                  r_reg_write <= 1'b1;
                  r_state     <= ST_WB;
               end else begin
                  r_ctrl    <= CTRL_NONE;
                  r_retired <= r_retired + 32'd1;
                  r_state   <= ST_FETCH;
               end
            end
            ST_WB: begin
               r_reg_write <= 1'b0;
               r_ctrl      <= CTRL_NONE;
               r_retired   <= r_retired + 32'd1;
               r_state     <= ST_FETCH;
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               // Corrupted state: park safely with every output quiet.
               r_ctrl      <= CTRL_NONE;
               r_reg_write <= 1'b0;
               r_mem_write <= 1'b0;
               r_mem_read  <= 1'b0;
               r_halt      <= 1'b1;
               r_state     <= ST_HALT;
            end
         endcase
      end
   end

   assign o_imem_addr   = r_pc[IMEM_AW+1:2];
   assign o_instruction = r_ir;
   assign o_reg_dst     = r_ctrl.reg_dst;
   assign o_alu_src     = r_ctrl.alu_src;
   assign o_mem_to_reg  = r_ctrl.mem_to_reg;
   assign o_alu_control = r_ctrl.alu_ctrl;
   assign o_reg_write   = r_reg_write;
   assign o_mem_write   = r_mem_write;
   assign o_mem_read    = r_mem_read;
   assign o_pc          = r_pc;
   assign o_halt        = r_halt;
   assign o_retired     = r_retired;

endmodule

// File: tb/tb_mips_control_sequencer.sv
module tb_mips_control_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        run2;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instruction;
   logic        reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg;
   logic [3:0]  alu_control;
   logic [31:0] pc;
   logic        halt;
   logic [31:0] retired;

   logic [5:0]  imem_addr2;
   logic [31:0] imem_data2;
   logic [31:0] instruction2;
   logic        reg_dst2, reg_write2, alu_src2, mem_write2, mem_read2, mem_to_reg2;
   logic [3:0]  alu_control2;
   logic [31:0] pc2;
   logic        halt2;
   logic [31:0] retired2;

   logic [31:0] rom [64];
   logic [31:0] rf [32];
   logic [31:0] dmem [64];
   logic [31:0] mem_rdata_r;
   logic [31:0] cyc = 32'd0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  strb;   // {reg_write, mem_write, mem_read}
      logic [31:0] cyc;
      logic [31:0] loc;    // dest register or memory address
      logic [31:0] data;
      logic [2:0]  stat;   // {reg_dst, alu_src, mem_to_reg}
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mips_control_sequencer #(.IMEM_AW(6), .RESET_PC(32'h0)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_run(run),
      .o_imem_addr(imem_addr), .i_imem_data(imem_data),
      .o_instruction(instruction),
      .o_reg_dst(reg_dst), .o_reg_write(reg_write), .o_alu_src(alu_src),
      .o_mem_write(mem_write), .o_mem_read(mem_read), .o_mem_to_reg(mem_to_reg),
      .o_alu_control(alu_control), .o_pc(pc), .o_halt(halt), .o_retired(retired)
   );

   mips_control_sequencer #(.IMEM_AW(6), .RESET_PC(32'hFC)) u_dut_wrap (
      .i_clk(clk), .i_reset(reset), .i_run(run2),
      .o_imem_addr(imem_addr2), .i_imem_data(imem_data2),
      .o_instruction(instruction2),
      .o_reg_dst(reg_dst2), .o_reg_write(reg_write2), .o_alu_src(alu_src2),
      .o_mem_write(mem_write2), .o_mem_read(mem_read2), .o_mem_to_reg(mem_to_reg2),
      .o_alu_control(alu_control2), .o_pc(pc2), .o_halt(halt2), .o_retired(retired2)
   );

   assign imem_data  = rom[imem_addr];
   assign imem_data2 = 32'h00221820;

   // Minimal datapath driven by the sequencer controls.
   logic [4:0]  f_rs, f_rt, f_rd, f_dest;
   logic [31:0] f_simm, f_alu, f_wb;
   assign f_rs   = instruction[25:21];
   assign f_rt   = instruction[20:16];
   assign f_rd   = instruction[15:11];
   assign f_simm = {{16{instruction[15]}}, instruction[15:0]};
   assign f_alu  = (alu_control == 4'b0101) ? rf[f_rs] + (alu_src ? f_simm : rf[f_rt]) : 32'h0;
   assign f_dest = reg_dst ? f_rd : f_rt;
   assign f_wb   = mem_to_reg ? mem_rdata_r : f_alu;

   always @(posedge clk) begin
      cyc <= cyc + 32'd1;
      if (reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
         for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
         mem_rdata_r <= 32'h0;
      end else begin
         if (reg_write && f_dest != 5'd0) rf[f_dest] <= f_wb;
         if (mem_write) dmem[f_alu[7:2]] <= rf[f_rt];
         if (mem_read)  mem_rdata_r <= dmem[f_alu[7:2]];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [2:0] strb, input logic [31:0] c, input logic [31:0] loc,
                           input logic [31:0] data, input logic [2:0] stat);
      exp_t e;
      e.strb = strb; e.cyc = c; e.loc = loc; e.data = data; e.stat = stat;
      sb_q.push_back(e);
   endtask

   // Scoreboard: every strobe cycle pops one expected event.
   always @(negedge clk) begin
      logic [2:0]  strb;
      logic [31:0] obs_loc, obs_data;
      exp_t        e;
      strb = {reg_write, mem_write, mem_read};
      if (strb != 3'b000) begin
         check_val("single_strobe", 32'($countones(strb)), 32'd1);
         if (sb_q.size() == 0) begin
            check_val("unexpected_strobe", {29'd0, strb}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            case (strb)
               3'b100:  begin obs_loc = {27'd0, f_dest}; obs_data = f_wb; end
               3'b010:  begin obs_loc = f_alu; obs_data = rf[f_rt]; end
               default: begin obs_loc = f_alu; obs_data = e.data; end
            endcase
            check_val("strobe_kind", {29'd0, strb}, {29'd0, e.strb});
            check_val("strobe_cycle", cyc, e.cyc);
            check_val("strobe_loc", obs_loc, e.loc);
            check_val("strobe_data", obs_data, e.data);
            check_val("static_ctrl", {29'd0, reg_dst, alu_src, mem_to_reg}, {29'd0, e.stat});
            check_val("alu_control", {28'd0, alu_control}, 32'd5);
         end
      end
   end

   initial begin
      logic [31:0] c;
      reset = 1'b1; run = 1'b0; run2 = 1'b0;
      for (int i = 0; i < 64; i++) rom[i] = 32'hFC000000;
      rom[0] = 32'h00221820;  // add r3,r1,r2
      rom[1] = 32'hAC020008;  // sw r2,8(r0)
      rom[2] = 32'h8C050008;  // lw r5,8(r0)
      rom[3] = 32'h20A6FFFF;  // addi r6,r5,-1
      rom[4] = 32'h00663820;  // add r7,r3,r6
      rom[5] = 32'hFC000000;  // halt

      repeat (3) @(negedge clk);
      check_val("rst_pc", pc, 32'h0);
      check_val("rst_ir", instruction, 32'h0);
      check_val("rst_retired", retired, 32'h0);
      check_val("rst_halt", {31'd0, halt}, 32'd0);
      check_val("rst_ctrls", {22'd0, reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg, alu_control}, 32'd0);
      check_val("rst_pc_wrap_dut", pc2, 32'hFC);
      check_val("rst_imem_addr_wrap_dut", {26'd0, imem_addr2}, 32'd63);
      reset = 1'b0;
      @(negedge clk);

      // T1: single add, then Run dropped; instruction must still finish.
      c = cyc + 32'd1;
      run = 1'b1;
      push_exp(3'b100, c + 32'd2, 32'd3, 32'd3, 3'b100);
      @(negedge clk);
      run = 1'b0;
      check_val("t1_ir", instruction, 32'h00221820);
      check_val("t1_regdst_read", {31'd0, reg_dst}, 32'd1);
      repeat (12) @(negedge clk);
      check_val("t1_retired", retired, 32'd1);
      check_val("t1_pc_idle", pc, 32'd4);
      check_val("t1_ctrl_fetch", {29'd0, reg_dst, alu_src, mem_to_reg}, 32'd0);

      // T2/T3 + halt: sw, lw, addi, add, halt back to back.
      c = cyc + 32'd1;
      run = 1'b1;
      push_exp(3'b010, c + 32'd2, 32'd8, 32'd2, 3'b010);   c = c + 32'd4;
      push_exp(3'b001, c + 32'd2, 32'd8, 32'd0, 3'b011);
      push_exp(3'b100, c + 32'd3, 32'd5, 32'd2, 3'b011);   c = c + 32'd5;
      push_exp(3'b100, c + 32'd2, 32'd6, 32'd1, 3'b010);   c = c + 32'd4;
      push_exp(3'b100, c + 32'd2, 32'd7, 32'd4, 3'b100);   c = c + 32'd4;
      while (cyc < c) @(negedge clk);
      check_val("halt_read_cycle", {31'd0, halt}, 32'd0);
      @(negedge clk);
      check_val("halt_next_cycle", {31'd0, halt}, 32'd1);
      repeat (10) @(negedge clk);
      check_val("halt_sticky", {31'd0, halt}, 32'd1);
      check_val("halt_retired", retired, 32'd5);
      check_val("halt_pc", pc, 32'd24);
      check_val("rf_r3", rf[3], 32'd3);
      check_val("rf_r5", rf[5], 32'd2);
      check_val("rf_r6", rf[6], 32'd1);
      check_val("rf_r7", rf[7], 32'd4);
      check_val("dmem_8", dmem[2], 32'd2);

      // T4: R-type with funct 0x22 is illegal.
      run = 1'b0; reset = 1'b1;
      rom[0] = 32'h00221822;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      c = cyc + 32'd1;
      run = 1'b1;
      while (cyc < c + 32'd1) @(negedge clk);
      check_val("illegal_halt", {31'd0, halt}, 32'd1);
      repeat (5) @(negedge clk);
      check_val("illegal_retired", retired, 32'd0);
      check_val("illegal_pc", pc, 32'd4);

      // T5: reset during the MEM cycle of a sw.
      run = 1'b0; reset = 1'b1;
      rom[0] = 32'hAC020008;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      c = cyc + 32'd1;
      run = 1'b1;
      push_exp(3'b010, c + 32'd2, 32'd8, 32'd2, 3'b010);
      while (cyc < c + 32'd2) @(negedge clk);
      reset = 1'b1;
      run = 1'b0;
      @(negedge clk);
      check_val("rstmid_memwrite", {31'd0, mem_write}, 32'd0);
      check_val("rstmid_pc", pc, 32'h0);
      check_val("rstmid_retired", retired, 32'h0);
      check_val("rstmid_halt", {31'd0, halt}, 32'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check_val("rstmid_idle_retired", retired, 32'h0);

      // T6: PC wrap from 0xFC.
      check_val("wrap_pc_before", pc2, 32'hFC);
      run2 = 1'b1;
      @(negedge clk);
      run2 = 1'b0;
      check_val("wrap_pc_after", pc2, 32'h0);
      check_val("wrap_imem_addr", {26'd0, imem_addr2}, 32'd0);
      repeat (6) @(negedge clk);
      check_val("wrap_retired", retired2, 32'd1);

      check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
